// File: rtl/register.sv
// Single W-bit storage element of the MIPS register file, optionally a hard-wired $zero.
// Optional write-through forwarding on the read port when REG_BYPASS_EN is defined.
module register #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
  parameter bit                 ZERO_REG    = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enabled,
  input  logic             addressed,
  input  logic [WIDTH-1:0] write,
  output logic [WIDTH-1:0] read
);

  generate
    if (ZERO_REG) begin : g_zero
      // $zero keeps no state at all, so no flops exist for q.
      assign read = {WIDTH{1'b0}};
    end else begin : g_reg
      logic             loadEn;
      logic [WIDTH-1:0] q_q;
      logic [WIDTH-1:0] q_d;

      assign loadEn = enabled & addressed;

      always_comb begin
        q_d = q_q;
        if (loadEn) begin
          q_d = write;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          q_q <= RESET_VALUE;
        end else begin
          q_q <= q_d;
        end
      end

`ifdef REG_BYPASS_EN
      // Forward the word being written so a same-cycle reader sees it before the edge.
      assign read = (loadEn && !RST) ? write : q_q;
`else
      assign read = q_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_register.sv
// Scoreboard bench for register: three instances (default, non-zero reset value, $zero)
// share one stimulus stream; a monitor process pops expectations and compares.
`timescale 1ns/100ps
module tb_register;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] RV = 32'hA5A5_0F0F;

  typedef struct {
    string            name;
    int unsigned      sel;
    logic [WIDTH-1:0] exp;
  } expEntry_t;

  logic             clock;
  logic             rst;
  logic             enabled;
  logic             addressed;
  logic [WIDTH-1:0] writeData;
  logic [WIDTH-1:0] readMain;
  logic [WIDTH-1:0] readRv;
  logic [WIDTH-1:0] readZero;

  expEntry_t expQ[$];
  event      sampleEv;
  int        checks = 0;
  int        errors = 0;

  register #(.WIDTH(WIDTH)) dutMain (
    .CLK(clock), .RST(rst), .enabled(enabled), .addressed(addressed),
    .write(writeData), .read(readMain)
  );

  register #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dutRv (
    .CLK(clock), .RST(rst), .enabled(enabled), .addressed(addressed),
    .write(writeData), .read(readRv)
  );

  register #(.WIDTH(WIDTH), .ZERO_REG(1'b1)) dutZero (
    .CLK(clock), .RST(rst), .enabled(enabled), .addressed(addressed),
    .write(writeData), .read(readZero)
  );

  // Period of 4 time units; rising edges at 2, 6, 10, ...
  initial begin
    clock = 1'b0;
    forever #2 clock = ~clock;
  end

  // Monitor: drains the scoreboard whenever the stimulus side flags a sample point.
  initial begin
    expEntry_t e;
    logic [WIDTH-1:0] actual;
    forever begin
      @(sampleEv);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        case (e.sel)
          0:       actual = readMain;
          1:       actual = readRv;
          default: actual = readZero;
        endcase
        checks++;
        if (actual !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s (dut %0d): read=%h expected=%h", e.name, e.sel, actual, e.exp);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expMain,
                             input logic [WIDTH-1:0] expRv);
    expEntry_t e;
    e.name = name; e.sel = 0; e.exp = expMain;     expQ.push_back(e);
    e.name = name; e.sel = 1; e.exp = expRv;       expQ.push_back(e);
    e.name = name; e.sel = 2; e.exp = '0;          expQ.push_back(e);
    ->sampleEv;
  endtask

  // Drive inputs on the falling edge, let one rising edge capture them, sample 1 unit later.
  task automatic applyStimulus(input logic r, input logic en, input logic ad,
                               input logic [WIDTH-1:0] w, input string name,
                               input logic [WIDTH-1:0] expMain,
                               input logic [WIDTH-1:0] expRv);
    @(negedge clock);
    rst = r; enabled = en; addressed = ad; writeData = w;
    @(posedge clock);
    #1;
    checkOutput(name, expMain, expRv);
  endtask

  initial begin
    rst = 1'b1; enabled = 1'b0; addressed = 1'b0; writeData = '0;

    applyStimulus(1, 0, 0, 32'h0000_0000, "reset",          32'h0000_0000, RV);
    applyStimulus(0, 0, 0, 32'h0000_0000, "post_reset",     32'h0000_0000, RV);

    applyStimulus(0, 0, 1, 32'hFFFF_1111, "en_low_block",   32'h0000_0000, RV);
    applyStimulus(0, 1, 1, 32'hFFFF_1111, "first_write",    32'hFFFF_1111, 32'hFFFF_1111);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 32'h0000_0001, "hold_en_low",  32'hFFFF_1111, 32'hFFFF_1111);
    end
    applyStimulus(0, 1, 1, 32'h0000_0001, "write_one",      32'h0000_0001, 32'h0000_0001);
    applyStimulus(0, 1, 1, 32'h0001_0001, "write_change",   32'h0001_0001, 32'h0001_0001);

    applyStimulus(0, 0, 1, 32'hF001_0001, "hold_en_low2",   32'h0001_0001, 32'h0001_0001);
    applyStimulus(0, 1, 0, 32'hF001_0001, "addr_low_block", 32'h0001_0001, 32'h0001_0001);
    applyStimulus(0, 1, 1, 32'hF001_0001, "addr_high_wr",   32'hF001_0001, 32'hF001_0001);

    applyStimulus(1, 1, 1, 32'hDEAD_BEEF, "reset_wins",     32'h0000_0000, RV);
    applyStimulus(0, 1, 1, 32'hCAFE_F00D, "write_resumes",  32'hCAFE_F00D, 32'hCAFE_F00D);
    applyStimulus(0, 0, 1, 32'hxxxx_xxxx, "x_write_hold",   32'hCAFE_F00D, 32'hCAFE_F00D);

    // Load condition pulses between edges but is gone again before the capturing edge.
    @(negedge clock);
    rst = 1'b0; enabled = 1'b0; addressed = 1'b1; writeData = 32'h0BAD_0BAD;
    #0.5 enabled = 1'b1;
    #0.5 enabled = 1'b0; writeData = 32'h1357_9BDF;
    @(posedge clock);
    #1;
    checkOutput("glitch_ignored", 32'hCAFE_F00D, 32'hCAFE_F00D);

`ifdef REG_BYPASS_EN
    @(negedge clock);
    enabled = 1'b1; addressed = 1'b1; writeData = 32'h1234_5678;
    #1;
    checkOutput("bypass_fwd", 32'h1234_5678, 32'h1234_5678);
    #0.5 addressed = 1'b0;
    #0.2;
    checkOutput("bypass_revert", 32'hCAFE_F00D, 32'hCAFE_F00D);
    @(posedge clock);
    #1;
    checkOutput("bypass_no_load", 32'hCAFE_F00D, 32'hCAFE_F00D);
`endif

    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
